// File: rtl/usb_dfu_flash_sequencer_if.sv
// Handshake bundle between the DFU flash sequencer and usb_spiflash_bridge.
interface usb_dfu_flash_sequencer_if;
  logic [15:0] flash_address;
  logic        rd_request;
  logic        rd_data_put;
  logic        wr_request;
  logic        wr_data_get;
  logic        wr_busy;

  // Sequencer side: drives page address and requests, sees byte handshakes.
  modport master (
    output flash_address, rd_request, wr_request,
    input  rd_data_put, wr_data_get, wr_busy
  );

  // Bridge side.
  modport slave (
    input  flash_address, rd_request, wr_request,
    output rd_data_put, wr_data_get, wr_busy
  );
endinterface

// File: rtl/usb_dfu_flash_sequencer.sv
// DFU block sequencer: maps a block number to a flash page, counts bytes through
// the bridge handshakes, waits out erase/program and posts a DFU bStatus code.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for dnload_start / upload_start
// S_WR_FILL   | wr_request high until len bytes consumed by the bridge
// S_WR_WAIT   | waiting for wr_busy to rise then fall, bounded by timeout
// S_RD_STREAM | rd_request high until len bytes delivered by the bridge
// S_POST      | seq_done pulse cycle, status visible, back to idle
module usb_dfu_flash_sequencer #(
  parameter int unsigned PAGE_SIZE      = 256,
  parameter logic [15:0] BASE_PAGE      = 16'h0400,
  parameter int unsigned MAX_PAGES      = 1024,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             dnload_start,
  input  logic                             upload_start,
  input  logic                             abort,
  input  logic [15:0]                      block_num,
  input  logic [8:0]                       xfer_len,
  output logic                             seq_busy,
  output logic                             seq_done,
  output logic [3:0]                       seq_status,
  usb_dfu_flash_sequencer_if.master        bridge
);

  localparam logic [16:0] MAX_PAGES_W  = 17'(MAX_PAGES);
  localparam logic [9:0]  PAGE_SIZE_W  = 10'(PAGE_SIZE);
  localparam logic [3:0]  ST_OK        = 4'h0;
  localparam logic [3:0]  ST_ERR_WRITE = 4'h3;
  localparam logic [3:0]  ST_ERR_ADDR  = 4'h8;
  localparam logic [3:0]  ST_ERR_UNK   = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FILL,
    S_WR_WAIT,
    S_RD_STREAM,
    S_POST
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic        seen_busy_q, seen_busy_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  status_q, status_d;

  logic [8:0]  cnt_inc;
  logic        cnt_lt_len;
  logic        bad_req;

  assign cnt_inc    = byte_cnt_q + 9'd1;
  assign cnt_lt_len = (byte_cnt_q < len_q);
  assign bad_req    = ({1'b0, block_num} >= MAX_PAGES_W) || ({1'b0, xfer_len} > PAGE_SIZE_W);

  // Next-state and next-register computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    seen_busy_d = seen_busy_q;
    abort_d     = abort_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    status_d    = status_q;

    case (state_q)
      S_IDLE: begin
        if (dnload_start || upload_start) begin
          if (bad_req) begin
            state_d  = S_POST;
            done_d   = 1'b1;
            status_d = ST_ERR_ADDR;
          end else if (xfer_len == 9'd0) begin
            // Zero-length download is the DFU manifest marker; nothing to move.
            state_d  = S_POST;
            done_d   = 1'b1;
            status_d = ST_OK;
          end else begin
            addr_d      = BASE_PAGE + block_num;
            len_d       = xfer_len;
            byte_cnt_d  = 9'd0;
            abort_d     = 1'b0;
            seen_busy_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = dnload_start ? S_WR_FILL : S_RD_STREAM;
          end
        end
      end

      S_WR_FILL: begin
        if (bridge.wr_data_get && cnt_lt_len) begin
          byte_cnt_d = cnt_inc;
        end
        // An abort cannot cancel a flash op already handed to the bridge, so
        // it still has to sit out erase/program before posting.
        if (abort || (bridge.wr_data_get && cnt_lt_len && (cnt_inc == len_q))) begin
          abort_d     = abort_q | abort;
          seen_busy_d = 1'b0;
          tmo_d       = TIMEOUT_CYCLES;
          state_d     = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (bridge.wr_busy) begin
          seen_busy_d = 1'b1;
        end
        if (seen_busy_q && !bridge.wr_busy) begin
          state_d  = S_POST;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          status_d = (abort_q || abort) ? ST_ERR_UNK : ST_OK;
        end else if (tmo_q <= 24'd1) begin
          state_d  = S_POST;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          status_d = ST_ERR_WRITE;
        end else begin
          tmo_d = tmo_q - 24'd1;
        end
      end

      S_RD_STREAM: begin
        if (abort) begin
          state_d  = S_POST;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          status_d = ST_ERR_UNK;
        end else if (bridge.rd_data_put && cnt_lt_len) begin
          byte_cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d  = S_POST;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            status_d = ST_OK;
          end
        end
      end

      S_POST: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'd0;
      len_q       <= 9'd0;
      byte_cnt_q  <= 9'd0;
      tmo_q       <= 24'd0;
      seen_busy_q <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      seen_busy_q <= seen_busy_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

  // Requests come straight from registers so they drop on the edge that
  // counts the final handshake.
  assign bridge.flash_address = addr_q;
  assign bridge.wr_request    = (state_q == S_WR_FILL) && cnt_lt_len;
  assign bridge.rd_request    = (state_q == S_RD_STREAM) && cnt_lt_len;

  assign seq_busy   = busy_q;
  assign seq_done   = done_q;
  assign seq_status = status_q;

endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
// Directed bench for usb_dfu_flash_sequencer with a hand-driven bridge model.
module tb_usb_dfu_flash_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        dnload_start;
  logic        upload_start;
  logic        abort;
  logic [15:0] block_num;
  logic [8:0]  xfer_len;
  logic        seq_busy;
  logic        seq_done;
  logic [3:0]  seq_status;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;
  int good;

  usb_dfu_flash_sequencer_if bus();

  usb_dfu_flash_sequencer #(
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dnload_start (dnload_start),
    .upload_start (upload_start),
    .abort        (abort),
    .block_num    (block_num),
    .xfer_len     (xfer_len),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .seq_status   (seq_status),
    .bridge       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input bit dn, input bit up, input logic [15:0] blk, input logic [8:0] len);
    dnload_start = dn;
    upload_start = up;
    block_num    = blk;
    xfer_len     = len;
    tick();
    dnload_start = 1'b0;
    upload_start = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b0;
    dnload_start     = 1'b0;
    upload_start     = 1'b0;
    abort            = 1'b0;
    block_num        = 16'd0;
    xfer_len         = 9'd0;
    bus.rd_data_put  = 1'b0;
    bus.wr_data_get  = 1'b0;
    bus.wr_busy      = 1'b0;
    repeat (3) tick();

    chk("rst_busy", 32'(seq_busy), 32'd0);
    chk("rst_done", 32'(seq_done), 32'd0);
    chk("rst_status", 32'(seq_status), 32'd0);
    chk("rst_addr", 32'(bus.flash_address), 32'd0);
    chk("rst_wr_req", 32'(bus.wr_request), 32'd0);
    chk("rst_rd_req", 32'(bus.rd_request), 32'd0);
    reset_n = 1'b1;
    tick();

    // Download block 3, 256 bytes, get every cycle, busy for 50 cycles.
    start_op(1'b1, 1'b0, 16'd3, 9'd256);
    chk("dn_wr_req_lat", 32'(bus.wr_request), 32'd1);
    chk("dn_busy", 32'(seq_busy), 32'd1);
    chk("dn_addr", 32'(bus.flash_address), 32'h0403);
    bus.wr_data_get = 1'b1;
    cnt = 0;
    n = 0;
    while (bus.wr_request && n < 400) begin
      cnt++;
      tick();
      n++;
    end
    bus.wr_data_get = 1'b0;
    chk("dn_gets", 32'(cnt), 32'd256);
    chk("dn_wait_busy", 32'(seq_busy), 32'd1);
    bus.wr_busy = 1'b1;
    repeat (50) tick();
    chk("dn_no_early_done", 32'(seq_done), 32'd0);
    bus.wr_busy = 1'b0;
    tick();
    chk("dn_done", 32'(seq_done), 32'd1);
    chk("dn_status", 32'(seq_status), 32'h0);
    chk("dn_busy_drop", 32'(seq_busy), 32'd0);
    tick();
    chk("dn_done_pulse", 32'(seq_done), 32'd0);
    chk("dn_addr_held", 32'(bus.flash_address), 32'h0403);

    // Upload block 0, 64 bytes, one put every 20 cycles.
    start_op(1'b0, 1'b1, 16'd0, 9'd64);
    chk("up_rd_req_lat", 32'(bus.rd_request), 32'd1);
    chk("up_addr", 32'(bus.flash_address), 32'h0400);
    good = 0;
    for (int p = 0; p < 64; p++) begin
      repeat (19) tick();
      if (bus.rd_request) good++;
      bus.rd_data_put = 1'b1;
      tick();
      bus.rd_data_put = 1'b0;
    end
    chk("up_puts_with_req", 32'(good), 32'd64);
    chk("up_rd_req_drop", 32'(bus.rd_request), 32'd0);
    chk("up_done", 32'(seq_done), 32'd1);
    chk("up_status", 32'(seq_status), 32'h0);
    tick();
    chk("up_done_pulse", 32'(seq_done), 32'd0);

    // Range and length rejects, manifest, and the last valid block.
    start_op(1'b1, 1'b0, 16'd1024, 9'd16);
    chk("blk1024_wr_req", 32'(bus.wr_request), 32'd0);
    chk("blk1024_done", 32'(seq_done), 32'd1);
    chk("blk1024_status", 32'(seq_status), 32'h8);
    chk("blk1024_busy", 32'(seq_busy), 32'd0);
    tick();
    chk("blk1024_status_held", 32'(seq_status), 32'h8);
    chk("blk1024_done_pulse", 32'(seq_done), 32'd0);

    start_op(1'b1, 1'b0, 16'd5, 9'd0);
    chk("len0_wr_req", 32'(bus.wr_request), 32'd0);
    chk("len0_done", 32'(seq_done), 32'd1);
    chk("len0_status", 32'(seq_status), 32'h0);
    tick();

    start_op(1'b1, 1'b0, 16'd5, 9'd257);
    chk("len257_wr_req", 32'(bus.wr_request), 32'd0);
    chk("len257_done", 32'(seq_done), 32'd1);
    chk("len257_status", 32'(seq_status), 32'h8);
    tick();

    start_op(1'b0, 1'b1, 16'd1023, 9'd1);
    chk("blk1023_rd_req", 32'(bus.rd_request), 32'd1);
    chk("blk1023_addr", 32'(bus.flash_address), 32'h07FF);
    bus.rd_data_put = 1'b1;
    tick();
    bus.rd_data_put = 1'b0;
    chk("blk1023_done", 32'(seq_done), 32'd1);
    chk("blk1023_status", 32'(seq_status), 32'h0);
    tick();

    // Both starts together: download wins; a start while busy is ignored.
    start_op(1'b1, 1'b1, 16'd2, 9'd4);
    chk("dual_wr_req", 32'(bus.wr_request), 32'd1);
    chk("dual_rd_req", 32'(bus.rd_request), 32'd0);
    chk("dual_addr", 32'(bus.flash_address), 32'h0402);
    bus.wr_data_get = 1'b1;
    cnt = 0;
    n = 0;
    while (bus.wr_request && n < 20) begin
      cnt++;
      tick();
      n++;
    end
    bus.wr_data_get = 1'b0;
    chk("dual_gets", 32'(cnt), 32'd4);
    start_op(1'b0, 1'b1, 16'd9, 9'd8);
    chk("busy_start_rd_req", 32'(bus.rd_request), 32'd0);
    chk("busy_start_addr", 32'(bus.flash_address), 32'h0402);
    bus.wr_busy = 1'b1;
    repeat (3) tick();
    bus.wr_busy = 1'b0;
    tick();
    chk("dual_done", 32'(seq_done), 32'd1);
    chk("dual_status", 32'(seq_status), 32'h0);
    tick();

    // Abort during upload.
    start_op(1'b0, 1'b1, 16'd9, 9'd8);
    bus.rd_data_put = 1'b1;
    tick();
    bus.rd_data_put = 1'b0;
    chk("up_abort_pre_req", 32'(bus.rd_request), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("up_abort_rd_req", 32'(bus.rd_request), 32'd0);
    chk("up_abort_done", 32'(seq_done), 32'd1);
    chk("up_abort_status", 32'(seq_status), 32'hE);
    tick();

    // Program never completes: timeout after 100 cycles in the wait state.
    start_op(1'b1, 1'b0, 16'd1, 9'd1);
    bus.wr_data_get = 1'b1;
    tick();
    bus.wr_data_get = 1'b0;
    bus.wr_busy = 1'b1;
    n = 0;
    while (!seq_done && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd100);
    chk("tmo_status", 32'(seq_status), 32'h3);
    bus.wr_busy = 1'b0;
    tick();
    chk("tmo_done_pulse", 32'(seq_done), 32'd0);
    chk("tmo_busy", 32'(seq_busy), 32'd0);

    // Abort after 10 gets during download.
    start_op(1'b1, 1'b0, 16'd7, 9'd32);
    bus.wr_data_get = 1'b1;
    repeat (10) tick();
    bus.wr_data_get = 1'b0;
    chk("dn_abort_pre_req", 32'(bus.wr_request), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("dn_abort_wr_req", 32'(bus.wr_request), 32'd0);
    chk("dn_abort_busy", 32'(seq_busy), 32'd1);
    chk("dn_abort_no_done", 32'(seq_done), 32'd0);
    bus.wr_busy = 1'b1;
    repeat (5) tick();
    bus.wr_busy = 1'b0;
    tick();
    chk("dn_abort_done", 32'(seq_done), 32'd1);
    chk("dn_abort_status", 32'(seq_status), 32'hE);
    tick();

    // Reset asserted in the middle of a write fill.
    start_op(1'b1, 1'b0, 16'd4, 9'd16);
    bus.wr_data_get = 1'b1;
    repeat (3) tick();
    chk("mid_rst_pre_req", 32'(bus.wr_request), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_req", 32'(bus.wr_request), 32'd0);
    chk("mid_rst_busy", 32'(seq_busy), 32'd0);
    chk("mid_rst_done", 32'(seq_done), 32'd0);
    chk("mid_rst_status", 32'(seq_status), 32'h0);
    chk("mid_rst_addr", 32'(bus.flash_address), 32'h0);
    bus.wr_data_get = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_wr_req", 32'(bus.wr_request), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
